// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: shared bus between two masters, the arbiter and MEMORY.
// Masters drive req/we/addr/wdata and receive ack/rdata; the arbiter drives
// MAR/mem_wdata/Mem_EN/Mem_CS and receives mem_rdata from the memory.
interface mem_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [7:0]  addr0;
   logic [7:0]  addr1;
   logic [15:0] wdata0;
   logic [15:0] wdata1;
   logic        ack0;
   logic        ack1;
   logic [15:0] rdata0;
   logic [15:0] rdata1;
   logic [7:0]  MAR;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        Mem_EN;
   logic        Mem_CS;

   modport slave (
      input  req0, req1, we0, we1,
      input  addr0, addr1, wdata0, wdata1,
      input  mem_rdata,
      output ack0, ack1, rdata0, rdata1,
      output MAR, mem_wdata, Mem_EN, Mem_CS
   );

   modport master (
      output req0, req1, we0, we1,
      output addr0, addr1, wdata0, wdata1,
      output mem_rdata,
      input  ack0, ack1, rdata0, rdata1,
      input  MAR, mem_wdata, Mem_EN, Mem_CS
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one 256x16 MEMORY, 4-cycle access.
// Ports: clock, reset_n (sync, active-low), bus (mem_arbiter_if.slave).
// ROUND_ROBIN=1 alternates priority on a tie; 0 gives port 0 fixed priority.
module mem_arbiter #(
   parameter int ROUND_ROBIN = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   mem_arbiter_if.slave bus
);
   localparam bit RR = (ROUND_ROBIN != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_CAPTURE,
      S_ACK
   } state_t;

   state_t      r_state;
   logic        r_last_grant;
   logic        r_grant;
   logic        r_we;
   logic [7:0]  r_mar;
   logic [15:0] r_mem_wdata;
   logic        r_mem_en;
   logic        r_mem_cs;
   logic        r_ack0;
   logic        r_ack1;
   logic [15:0] r_rdata0;
   logic [15:0] r_rdata1;

   logic        w_any;
   logic        w_pick1;
   logic        w_we;
   logic [7:0]  w_addr;
   logic [15:0] w_wdata;

   assign w_any = bus.req0 | bus.req1;

   // Port 1 wins when alone, or on a tie when port 0 was granted last.
   assign w_pick1 = bus.req1 &
                    (~bus.req0 | (RR & ~r_last_grant));

   assign w_we    = w_pick1 ? bus.we1    : bus.we0;
   assign w_addr  = w_pick1 ? bus.addr1  : bus.addr0;
   assign w_wdata = w_pick1 ? bus.wdata1 : bus.wdata0;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_we         <= 1'b0;
         r_mar        <= '0;
         r_mem_wdata  <= '0;
         r_mem_en     <= 1'b0;
         r_mem_cs     <= 1'b0;
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant      <= w_pick1;
                  r_last_grant <= w_pick1;
                  r_we         <= w_we;
                  // Memory strobes are registered here so
                  // they are live throughout ACCESS.
                  r_mar        <= w_addr;
                  r_mem_en     <= w_we;
                  r_mem_wdata  <= w_we ? w_wdata : '0;
                  r_mem_cs     <= 1'b1;
                  r_state      <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_mar       <= '0;
               r_mem_wdata <= '0;
               r_mem_en    <= 1'b0;
               r_mem_cs    <= 1'b0;
               r_state     <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // Memory presents its read data one edge
               // after the chip-select edge.
               if (!r_we) begin
                  if (r_grant) begin
                     r_rdata1 <= bus.mem_rdata;
                  end else begin
                     r_rdata0 <= bus.mem_rdata;
                  end
               end
               r_ack0  <= ~r_grant;
               r_ack1  <= r_grant;
               r_state <= S_ACK;
            end
            S_ACK: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack0      = r_ack0;
   assign bus.ack1      = r_ack1;
   assign bus.rdata0    = r_rdata0;
   assign bus.rdata1    = r_rdata1;
   assign bus.MAR       = r_mar;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.Mem_EN    = r_mem_en;
   assign bus.Mem_CS    = r_mem_cs;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter in both priority modes.
// Instance 0 is round-robin, instance 1 is fixed priority.
module tb_mem_arbiter;
   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic [15:0] wdata;
      int          lat;
   } txn_t;

   typedef struct {
      int          port;
      logic [15:0] rdata;
      bit          gap;
   } ack_t;

   typedef struct {
      logic [7:0]  addr;
      logic        we;
      logic [15:0] wdata;
   } acc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   logic        req_d   [2][2];
   logic        we_d    [2][2];
   logic [7:0]  addr_d  [2][2];
   logic [15:0] wdata_d [2][2];
   logic        ack_o   [2][2];
   logic [15:0] rdata_o [2][2];

   txn_t drvq [4][$];
   ack_t ackq [2][$];
   acc_t accq [2][$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if bus [2] ();

   task automatic chk(input int d, input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL dut%0d %s: got %0h want %0h",
                  d, nm, act, exp_v);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [15:0] mem [256];
      logic [15:0] mem_q;
      int          cs_cyc;
      int          ack_cyc;
      acc_t        a;
      ack_t        k;

      assign bus[g].req0      = req_d[g][0];
      assign bus[g].req1      = req_d[g][1];
      assign bus[g].we0       = we_d[g][0];
      assign bus[g].we1       = we_d[g][1];
      assign bus[g].addr0     = addr_d[g][0];
      assign bus[g].addr1     = addr_d[g][1];
      assign bus[g].wdata0    = wdata_d[g][0];
      assign bus[g].wdata1    = wdata_d[g][1];
      assign bus[g].mem_rdata = mem_q;
      assign ack_o[g][0]      = bus[g].ack0;
      assign ack_o[g][1]      = bus[g].ack1;
      assign rdata_o[g][0]    = bus[g].rdata0;
      assign rdata_o[g][1]    = bus[g].rdata1;

      mem_arbiter #(
         .ROUND_ROBIN(g == 0 ? 1 : 0)
      ) u_dut (
         .clock   (clk),
         .reset_n (rst_n),
         .bus     (bus[g])
      );

      always @(posedge clk) begin
         if (!rst_n) begin
            mem[10] <= 16'h1010;
            mem[20] <= 16'h2020;
            mem[30] <= 16'h3030;
            mem_q   <= '0;
         end else if (bus[g].Mem_CS) begin
            if (bus[g].Mem_EN)
               mem[bus[g].MAR] <= bus[g].mem_wdata;
            else
               mem_q <= mem[bus[g].MAR];
         end
      end

      always @(negedge clk) begin
         if (bus[g].Mem_CS === 1'b1) begin
            cs_cyc = cyc;
            if (accq[g].size() == 0) begin
               total++;
               bad++;
               $display("FAIL dut%0d extra Mem_CS: MAR=%0d",
                        g, bus[g].MAR);
            end else begin
               a = accq[g].pop_front();
               chk(g, "MAR", 32'(bus[g].MAR), 32'(a.addr));
               chk(g, "Mem_EN", 32'(bus[g].Mem_EN), 32'(a.we));
               chk(g, "mem_wdata", 32'(bus[g].mem_wdata),
                   32'(a.wdata));
            end
         end else begin
            chk(g, "idle bus",
                32'({bus[g].MAR, bus[g].mem_wdata,
                     bus[g].Mem_EN, bus[g].Mem_CS}), 32'd0);
         end
         if (ack_o[g][0] === 1'b1 || ack_o[g][1] === 1'b1) begin
            if (ackq[g].size() == 0) begin
               total++;
               bad++;
               $display("FAIL dut%0d extra ack: ack1=%b ack0=%b",
                        g, ack_o[g][1], ack_o[g][0]);
            end else begin
               k = ackq[g].pop_front();
               chk(g, "ack port",
                   32'({ack_o[g][1], ack_o[g][0]}),
                   (k.port == 1) ? 32'd2 : 32'd1);
               chk(g, "rdata", 32'(rdata_o[g][k.port]),
                   32'(k.rdata));
               chk(g, "cs-to-ack", 32'(cyc - cs_cyc), 32'd2);
               if (k.gap)
                  chk(g, "ack gap", 32'(cyc - ack_cyc), 32'd4);
            end
            ack_cyc = cyc;
         end
      end
   end

   task automatic txn(input int d, input int p,
                      input logic [7:0] ad, input logic w,
                      input logic [15:0] wd, input int lat);
      txn_t t;
      t.addr = ad;
      t.we = w;
      t.wdata = wd;
      t.lat = lat;
      drvq[d*2+p].push_back(t);
   endtask

   task automatic exp_ack(input int d, input int p,
                          input logic [15:0] rd, input bit gap);
      ack_t k;
      k.port = p;
      k.rdata = rd;
      k.gap = gap;
      ackq[d].push_back(k);
   endtask

   task automatic exp_acc(input int d, input logic [7:0] ad,
                          input logic w, input logic [15:0] wd);
      acc_t a;
      a.addr = ad;
      a.we = w;
      a.wdata = wd;
      accq[d].push_back(a);
   endtask

   task automatic run_port(input int d, input int p);
      txn_t t;
      int   n;
      while (drvq[d*2+p].size() > 0) begin
         t = drvq[d*2+p].pop_front();
         req_d[d][p]   = 1'b1;
         we_d[d][p]    = t.we;
         addr_d[d][p]  = t.addr;
         wdata_d[d][p] = t.wdata;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (ack_o[d][p] !== 1'b1 && n < 40);
         if (ack_o[d][p] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL dut%0d port%0d ack timeout: got none want ack",
                     d, p);
            break;
         end
         if (t.lat != 0)
            chk(d, "ack latency", 32'(n), 32'(t.lat));
      end
      req_d[d][p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            req_d[d][p]   = 1'b0;
            we_d[d][p]    = 1'b0;
            addr_d[d][p]  = '0;
            wdata_d[d][p] = '0;
         end
      end

      // reset held two cycles with both ports requesting
      rst_n = 1'b0;
      req_d[0][0]  = 1'b1;
      req_d[0][1]  = 1'b1;
      addr_d[0][0] = 8'd10;
      addr_d[0][1] = 8'd20;
      repeat (2) @(negedge clk);
      chk(0, "rst ack0", 32'(ack_o[0][0]), 32'd0);
      chk(0, "rst ack1", 32'(ack_o[0][1]), 32'd0);
      chk(0, "rst rdata0", 32'(rdata_o[0][0]), 32'd0);
      chk(0, "rst rdata1", 32'(rdata_o[0][1]), 32'd0);
      rst_n = 1'b1;
      txn(0, 0, 8'd10, 1'b0, 16'h0, 3);
      txn(0, 1, 8'd20, 1'b0, 16'h0, 7);
      exp_acc(0, 8'd10, 1'b0, 16'h0);
      exp_acc(0, 8'd20, 1'b0, 16'h0);
      exp_ack(0, 0, 16'h1010, 1'b0);
      exp_ack(0, 1, 16'h2020, 1'b1);
      fork
         run_port(0, 0);
         run_port(0, 1);
      join
      repeat (2) @(negedge clk);

      // port 0 write then back-to-back read
      txn(0, 0, 8'd4, 1'b1, 16'd96, 3);
      txn(0, 0, 8'd4, 1'b0, 16'h0, 4);
      exp_acc(0, 8'd4, 1'b1, 16'd96);
      exp_acc(0, 8'd4, 1'b0, 16'h0);
      exp_ack(0, 0, 16'h1010, 1'b0);
      exp_ack(0, 0, 16'd96, 1'b1);
      run_port(0, 0);
      repeat (2) @(negedge clk);

      // round-robin contention; port 0 went last, so port 1 first
      txn(0, 0, 8'd10, 1'b0, 16'h0, 7);
      txn(0, 0, 8'd10, 1'b0, 16'h0, 8);
      txn(0, 1, 8'd20, 1'b0, 16'h0, 3);
      txn(0, 1, 8'd20, 1'b0, 16'h0, 8);
      exp_acc(0, 8'd20, 1'b0, 16'h0);
      exp_acc(0, 8'd10, 1'b0, 16'h0);
      exp_acc(0, 8'd20, 1'b0, 16'h0);
      exp_acc(0, 8'd10, 1'b0, 16'h0);
      exp_ack(0, 1, 16'h2020, 1'b0);
      exp_ack(0, 0, 16'h1010, 1'b1);
      exp_ack(0, 1, 16'h2020, 1'b1);
      exp_ack(0, 0, 16'h1010, 1'b1);
      fork
         run_port(0, 0);
         run_port(0, 1);
      join
      repeat (2) @(negedge clk);

      // cross-port coherency at the top address
      txn(0, 1, 8'd255, 1'b1, 16'hBEEF, 3);
      exp_acc(0, 8'd255, 1'b1, 16'hBEEF);
      exp_ack(0, 1, 16'h2020, 1'b0);
      run_port(0, 1);
      repeat (2) @(negedge clk);
      txn(0, 0, 8'd255, 1'b0, 16'h0, 3);
      exp_acc(0, 8'd255, 1'b0, 16'h0);
      exp_ack(0, 0, 16'hBEEF, 1'b0);
      run_port(0, 0);
      repeat (2) @(negedge clk);

      // reset lands in the CAPTURE cycle of a port-1 read
      exp_acc(0, 8'd20, 1'b0, 16'h0);
      req_d[0][1]  = 1'b1;
      we_d[0][1]   = 1'b0;
      addr_d[0][1] = 8'd20;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      req_d[0][1] = 1'b0;
      @(negedge clk);
      chk(0, "abort ack1", 32'(ack_o[0][1]), 32'd0);
      chk(0, "abort rdata1", 32'(rdata_o[0][1]), 32'd0);
      chk(0, "abort rdata0", 32'(rdata_o[0][0]), 32'd0);
      rst_n = 1'b1;
      txn(0, 1, 8'd30, 1'b0, 16'h0, 3);
      exp_acc(0, 8'd30, 1'b0, 16'h0);
      exp_ack(0, 1, 16'h3030, 1'b0);
      run_port(0, 1);
      repeat (2) @(negedge clk);

      // fixed priority: port 0 keeps winning while it asks
      txn(1, 0, 8'd10, 1'b0, 16'h0, 3);
      txn(1, 0, 8'd20, 1'b0, 16'h0, 4);
      txn(1, 0, 8'd30, 1'b0, 16'h0, 4);
      txn(1, 1, 8'd20, 1'b0, 16'h0, 15);
      exp_acc(1, 8'd10, 1'b0, 16'h0);
      exp_acc(1, 8'd20, 1'b0, 16'h0);
      exp_acc(1, 8'd30, 1'b0, 16'h0);
      exp_acc(1, 8'd20, 1'b0, 16'h0);
      exp_ack(1, 0, 16'h1010, 1'b0);
      exp_ack(1, 0, 16'h2020, 1'b1);
      exp_ack(1, 0, 16'h3030, 1'b1);
      exp_ack(1, 1, 16'h2020, 1'b1);
      fork
         run_port(1, 0);
         run_port(1, 1);
      join
      repeat (4) @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         chk(d, "acks left", 32'(ackq[d].size()), 32'd0);
         chk(d, "accesses left", 32'(accq[d].size()), 32'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256x16 `MEMORY` between two bus masters (port 0: CPU fetch/execute path; port 1: secondary master such as a DMA/loader). It sits between the masters and `MEMORY`. It drives `MAR`, the memory write data, `Mem_EN` and `Mem_CS`, and it sequences each access as a fixed 4-cycle transaction with a request/acknowledge handshake per port.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate priority on contention; 0 = fixed priority, port 0 always wins.
- One clock; reset is synchronous and active-low.
- `clock`  in  1: single system clock; all state changes on posedge.
- `reset_n`  in  1: synchronous, active-low reset.
- `req0` / `req1`  in  1: access request, level; held until `ack` is seen.
- `we0` / `we1`  in  1: 1 = write, 0 = read; stable while `req` is high.
- `addr0` / `addr1`  in  8: word address; stable while `req` is high.
- `wdata0` / `wdata1`  in  16: write data; stable while `req` is high.
- `ack0` / `ack1`  out  1: one-cycle completion pulse.
- `rdata0` / `rdata1`  out  16: read data, valid while `ack` is high, held until the next read on that port.
- `MAR`  out  8: memory address.
- `mem_wdata`  out  16: data to memory `data_in`.
- `mem_rdata`  in  16: memory `data_out`.
- `Mem_EN`  out  1: memory write enable (1 = write, 0 = read).
- `Mem_CS`  out  1: memory chip select; the memory acts on posedge while it is high.

## Operation
- FSM states: IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE; all outputs registered.
- IDLE: sample `req0`/`req1` at posedge. If neither is high, stay in IDLE. If any is high, pick the winner, latch its addr/we/wdata, record `grant_id`, and go to ACCESS.
- Arbitration with ROUND_ROBIN=1: if only one port requests, that port wins. If both request, the port not equal to `last_grant` wins. `last_grant` updates on each grant. Reset value of `last_grant` is 1, so port 0 wins the first tie.
- Arbitration with ROUND_ROBIN=0: port 0 wins any tie.
- ACCESS: `Mem_CS`=1, `MAR`=latched addr, `Mem_EN`=latched we, `mem_wdata`=latched wdata (0 on reads). Exactly one cycle, then go to CAPTURE.
- CAPTURE: `Mem_CS`=0, `Mem_EN`=0. On reads, register `mem_rdata` into the granted port's `rdata` at the end of this cycle. On writes, `rdata` is unchanged. Then go to ACK.
- ACK: assert `ack` of the granted port only, for one cycle, then go to IDLE.
- Master rule: on the posedge where a master samples `ack`=1, it either drops `req` or presents a new addr/we/wdata with `req` still high. A `req` still high in the next IDLE cycle is a new transaction.
- The losing port's `req` stays pending. It is served in the next IDLE cycle; there is no starvation under ROUND_ROBIN=1.
- Outside ACCESS: `MAR`=0, `mem_wdata`=0, `Mem_EN`=0, `Mem_CS`=0.

## Timing
- `req` high in IDLE cycle T. Then: `Mem_CS` high in cycle T+1, memory read data captured at the end of T+2, `ack` and `rdata` valid in cycle T+3, FSM back in IDLE at T+4.
- Throughput: one access per 4 cycles. Back-to-back accesses from either port have no extra bubble.
- Requests arriving while the FSM is not in IDLE wait. They are sampled only in IDLE.
- Reset values when `reset_n`=0 at posedge:
  - state = IDLE, `last_grant` = 1
  - `ack0` = `ack1` = 0
  - `rdata0` = `rdata1` = 0
  - `MAR` = 0, `mem_wdata` = 0, `Mem_EN` = 0, `Mem_CS` = 0
- Reset mid-transaction: the transaction is aborted, no `ack` is issued, and all outputs are 0 from the next cycle.
- A write whose ACCESS edge coincides with the reset edge may or may not commit. Masters must reissue any access aborted by reset.
- `we`/`addr`/`wdata` changes during a transaction, other than at the `ack` edge, are ignored because they are latched in IDLE.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `req0`=`req1`=1 -> all outputs 0, no `Mem_CS`; after release, port 0 is granted first.
- Single write/read: port 0 writes 16'd96 to addr 4, then reads addr 4 -> `Mem_CS` pulses in T+1 with `MAR`=4 and `Mem_EN`=1; the read gives `ack0` at T+3 with `rdata0`=96, and `ack1` stays 0.
- Contention, ROUND_ROBIN=1: both ports hold `req` continuously, reading addrs 10 and 20 -> grants alternate 0,1,0,1; each `ack` is spaced 4 cycles apart; `rdata` matches the preloaded memory contents.
- Contention, ROUND_ROBIN=0: both ports hold `req` for 3 transactions -> port 0 is served 3 times consecutively; port 1 is served only after port 0 drops `req`.
- Cross-port coherency: port 1 writes 16'hBEEF to addr 255, then port 0 reads addr 255 -> `rdata0`=16'hBEEF; `rdata1` is unchanged by its own write.
- Reset mid-transaction: assert `reset_n`=0 in the CAPTURE cycle of a port-1 read -> no `ack1`; `rdata1`=0; the next request after reset completes normally in 4 cycles.
